// File: rtl/capture_if.sv
// Host-command / sample / FIFO bundle for the capture sequencer.
// The master drives commands, samples and FIFO status; the slave is capture_ctrl.
interface capture_if #(
  parameter int DATA_LEN = 32
);
  logic                cmd_valid;
  logic [DATA_LEN-1:0] cmd_data;
  logic [DATA_LEN-1:0] sample_in;
  logic                fifo_full;
  logic                fifo_push_n;
  logic [DATA_LEN-1:0] fifo_data;
  logic                capture_busy;
  logic [DATA_LEN-1:0] status;

  modport master (
    output cmd_valid, cmd_data, sample_in, fifo_full,
    input  fifo_push_n, fifo_data, capture_busy, status
  );

  modport slave (
    input  cmd_valid, cmd_data, sample_in, fifo_full,
    output fifo_push_n, fifo_data, capture_busy, status
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: host command decode, rate divider, masked trigger and FIFO push gating.
// Optional macro CAPTURE_TRIG_EDGE_EN selects a rising-match trigger instead of a level trigger.
module capture_ctrl #(
  parameter int DATA_LEN = 32,
  parameter int TRIG_W   = 16,
  parameter int CNT_W    = 24
) (
  input  logic     clk,
  input  logic     rst_n,
  capture_if.slave bus
);

  localparam logic [DATA_LEN-1:0] START_WORD = 32'h1111_1111;
  localparam logic [DATA_LEN-1:0] STOP_WORD  = '0;
  localparam logic [7:0] OP_DIV   = 8'hA1;
  localparam logic [7:0] OP_COUNT = 8'hA2;
  localparam logic [7:0] OP_VAL   = 8'hA3;
  localparam logic [7:0] OP_MASK  = 8'hA4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    div, count, remaining, div_cnt;
  logic [TRIG_W-1:0]   trig_val, trig_mask;
  logic                overflow, done;
  logic                vld_p1;
  logic [DATA_LEN-1:0] data_p1;

  logic cfg_ok, running, cmd_start, cmd_stop, strobe, match, trig_hit;
  logic start_go, take, push_ok, ovf_hit, last_push;
  logic [7:0] opcode;

  assign cfg_ok    = (state == IDLE) || (state == DONE);
  assign running   = (state == ARMED) || (state == CAPTURE);
  assign cmd_start = bus.cmd_valid && (bus.cmd_data == START_WORD);
  assign cmd_stop  = bus.cmd_valid && (bus.cmd_data == STOP_WORD);
  assign opcode    = bus.cmd_data[DATA_LEN-1 -: 8];
  assign strobe    = running && (div_cnt == div);
  assign match     = ((bus.sample_in[TRIG_W-1:0] ^ trig_val) & trig_mask) == '0;

`ifdef CAPTURE_TRIG_EDGE_EN
  // Match seen on the previous ARMED strobe; START presets it so the first strobe cannot fire.
  logic prev_match;
  assign trig_hit = match && !prev_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prev_match <= 1'b0;
    else if (start_go)
      prev_match <= 1'b1;
    else if (state == ARMED && strobe && !cmd_stop)
      prev_match <= match;
  end
`else
  assign trig_hit = match;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // STOP outranks everything; START outranks a coincident strobe.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    take      = 1'b0;
    if (cmd_stop) begin
      state_nxt = IDLE;
    end else if (cmd_start && cfg_ok) begin
      state_nxt = ARMED;
      start_go  = 1'b1;
    end else if (strobe) begin
      case (state)
        ARMED: if (trig_hit) begin
          state_nxt = CAPTURE;
          take      = 1'b1;
        end
        CAPTURE: take = 1'b1;
        default: ;
      endcase
    end
    push_ok   = take && !bus.fifo_full;
    ovf_hit   = take && bus.fifo_full;
    last_push = push_ok && (count != '0) && (remaining == CNT_W'(1));
    if (last_push) state_nxt = DONE;
  end

  // p0 -> p1: strobe decision registered into the FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      div       <= '0;
      count     <= '0;
      trig_val  <= '0;
      trig_mask <= '0;
      remaining <= '0;
      div_cnt   <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      vld_p1 <= push_ok;
      if (push_ok) data_p1 <= bus.sample_in;

      if (start_go) begin
        overflow  <= 1'b0;
        done      <= 1'b0;
        remaining <= count;
        div_cnt   <= '0;
      end else begin
        if (running) div_cnt <= strobe ? '0 : div_cnt + CNT_W'(1);
        if (ovf_hit) overflow <= 1'b1;
        if (push_ok && count != '0) remaining <= remaining - CNT_W'(1);
        if (last_push) done <= 1'b1;
      end

      if (bus.cmd_valid && cfg_ok) begin
        case (opcode)
          OP_DIV:   div       <= bus.cmd_data[CNT_W-1:0];
          OP_COUNT: count     <= bus.cmd_data[CNT_W-1:0];
          OP_VAL:   trig_val  <= bus.cmd_data[TRIG_W-1:0];
          OP_MASK:  trig_mask <= bus.cmd_data[TRIG_W-1:0];
          default:  ;
        endcase
      end
    end
  end

  assign bus.fifo_push_n  = ~vld_p1;
  assign bus.fifo_data    = data_p1;
  assign bus.capture_busy = running;
  assign bus.status       = {overflow, done, state, 4'b0000, remaining};

endmodule
